// File: rtl/div_pkg.sv
// Shared types and widths for the iterative integer divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    DONE
  } state_e;

  localparam int XLEN_W = 64;
  localparam int WORD_W = 32;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quot} left, trial subtract, keep or restore.
module div_step #(
  parameter int N = 64
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quot,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_nxt,
  output logic [N-1:0] quot_nxt
);

  logic [N:0]   shifted;
  logic [N-1:0] diff;
  logic         fits;

  always_comb begin
    shifted = {rem, quot[N-1]};
    fits    = (shifted >= {1'b0, divisor});
    // When the divisor fits, the true difference is below the divisor, so N bits suffice.
    diff    = shifted[N-1:0] - divisor;
    if (fits) begin
      rem_nxt  = diff;
      quot_nxt = {quot[N-2:0], 1'b1};
    end else begin
      rem_nxt  = shifted[N-1:0];
      quot_nxt = {quot[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/int_div_iter.sv
// Iterative restoring divider for RV64 DIV/DIVU/REM/REMU (and W-forms), one quotient bit per cycle.
module int_div_iter
  import div_pkg::*;
#(
  parameter int N     = XLEN_W,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(N);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  op_e              op_q, op_d;
  logic             word_q, word_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic [N-1:0]     rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;

  logic             is_signed, is_rem, a_neg, b_neg, b_zero, ovf;
  logic [N-1:0]     a_ext, b_ext, a_mag, b_mag, dvd_init;
  logic [N-1:0]     step_rem, step_quot, q_signed, r_signed;

  function automatic logic [N-1:0] sext_w(input logic [N-1:0] v, input logic word);
    return word ? {{(N-WORD_W){v[WORD_W-1]}}, v[WORD_W-1:0]} : v;
  endfunction

  div_step #(.N(N)) u_step (
    .rem      (rem_q),
    .quot     (quot_q),
    .divisor  (dvsr_q),
    .rem_nxt  (step_rem),
    .quot_nxt (step_quot)
  );

  // Operand conditioning: reduce to width W, take magnitudes, detect special cases.
  always_comb begin
    is_signed = (op_q == DIV) || (op_q == REM);
    is_rem    = (op_q == REM) || (op_q == REMU);
    if (word_q) begin
      a_ext = {{(N-WORD_W){is_signed & a_q[WORD_W-1]}}, a_q[WORD_W-1:0]};
      b_ext = {{(N-WORD_W){is_signed & b_q[WORD_W-1]}}, b_q[WORD_W-1:0]};
      ovf   = is_signed && (a_q[WORD_W-1:0] == {1'b1, {(WORD_W-1){1'b0}}})
                        && (b_q[WORD_W-1:0] == {WORD_W{1'b1}});
    end else begin
      a_ext = a_q;
      b_ext = b_q;
      ovf   = is_signed && (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == {N{1'b1}});
    end
    a_neg    = is_signed & a_ext[N-1];
    b_neg    = is_signed & b_ext[N-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    // W-form magnitudes fit in 32 bits; left-align so the MSB is shifted out first.
    dvd_init = word_q ? (a_mag << WORD_W) : a_mag;
    b_zero   = (b_ext == '0);
    q_signed = qneg_q ? -step_quot : step_quot;
    r_signed = rneg_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    tag_d    = tag_q;
    op_d     = op_q;
    word_d   = word_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op_e'(in_op);
          word_d  = in_word;
          a_d     = in_a;
          b_d     = in_b;
          tag_d   = in_tag;
          state_d = PREP;
        end
      end
      PREP: begin
        if (b_zero) begin
          result_d = is_rem ? sext_w(a_q, word_q) : {N{1'b1}};
          state_d  = DONE;
        end else if (ovf) begin
          result_d = is_rem ? '0 : sext_w(a_q, word_q);
          state_d  = DONE;
        end else begin
          rem_d   = '0;
          quot_d  = dvd_init;
          dvsr_d  = b_mag;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          cnt_d   = word_q ? CW'(WORD_W - 1) : CW'(N - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        if (cnt_q == '0) begin
          result_d = sext_w(is_rem ? r_signed : q_signed, word_q);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    word_q <= word_d;
    a_q    <= a_d;
    b_q    <= b_d;
    rem_q  <= rem_d;
    quot_q <= quot_d;
    dvsr_q <= dvsr_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_int_div_iter.sv
// Directed and random bench for int_div_iter against a plain-arithmetic RISC-V division model.
module tb_int_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic        in_word = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [5:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [5:0]  out_tag;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_res = '0;
  logic [5:0]  exp_tag = '0;

  int_div_iter #(.N(64), .TAG_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // RISC-V M-extension result rules, written directly with language division operators.
  function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        ua32, ub32, r32;
    logic [63:0]        r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    r = '0; r32 = '0;
    if (!w) begin
      case (op)
        2'd0: if (b == 0) r = '1;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
              else r = sa / sb;
        2'd1: if (b == 0) r = '1; else r = a / b;
        2'd2: if (b == 0) r = a;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
              else r = sa % sb;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end else begin
      case (op)
        2'd0: if (ub32 == 0) r32 = '1;
              else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
              else r32 = sa32 / sb32;
        2'd1: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
        2'd2: if (ub32 == 0) r32 = ua32;
              else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = '0;
              else r32 = sa32 % sb32;
        default: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  // While a result is presented it must match the model, stay stable, and block new requests.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("result", out_result, exp_res);
      check("tag", {58'd0, out_tag}, {58'd0, exp_tag});
      check("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] tag, input int hold,
                        input logic has_pin, input logic [63:0] pin);
    int   k;
    int   exp_lat;
    logic special;
    exp_res = model(op, w, a, b);
    exp_tag = tag;
    if (has_pin) check("model_pin", exp_res, pin);
    if (w) special = (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   special = (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    exp_lat = special ? 2 : (w ? 34 : 66);
    @(negedge clk);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b; in_tag = tag;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL latency_timeout: no out_valid within %0d cycles, expected %0d", k, exp_lat);
    end else begin
      check("latency", 64'(k), 64'(exp_lat));
    end
    if (hold > 0) begin
      in_valid = 1'b1; in_a = ~a; in_tag = ~tag;
      repeat (hold) @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("out_valid_one_shot", {63'd0, out_valid}, 64'd0);
    check("in_ready_after", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic saw;
    logic [1:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;
    int          sel;

    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", {58'd0, out_tag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'd1, 1'b0, 64'd100, 64'd7, 6'd1, 0, 1'b1, 64'd14);
    run_op(2'd3, 1'b0, 64'd100, 64'd7, 6'd2, 0, 1'b1, 64'd2);
    run_op(2'd0, 1'b0, -64'sd7, 64'd2, 6'd3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 1'b0, -64'sd7, 64'd2, 6'd4, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(2'd0, 1'b0, 64'd5, 64'd0, 6'd5, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(2'd3, 1'b0, 64'd5, 64'd0, 6'd6, 0, 1'b1, 64'd5);
    run_op(2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 6'd7, 0, 1'b1, 64'h8000_0000_0000_0000);
    run_op(2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 6'd8, 0, 1'b1, 64'd0);
    run_op(2'd0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 6'd9, 0, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_op(2'd1, 1'b1, 64'h1_0000_0064, 64'd10, 6'd10, 0, 1'b1, 64'd10);
    run_op(2'd2, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 6'd11, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(2'd1, 1'b1, 64'hFFFF_FFFE, 64'd1, 6'd12, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'd3, 1'b1, 64'hFFFF_FFFF, 64'h10, 6'd13, 0, 1'b1, 64'hF);
    run_op(2'd1, 1'b0, '1, 64'd1, 6'd14, 5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush during CALC: nothing may come out and the unit must be idle again.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_word = 1'b0; in_a = 64'd1000; in_b = 64'd3; in_tag = 6'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_tag = 6'd21;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("flush_no_result", {63'd0, saw}, 64'd0);
    check("flush_stays_idle", {63'd0, in_ready}, 64'd1);

    // Flush in DONE discards a same-cycle out_ready handshake.
    exp_res = model(2'd0, 1'b0, 64'd5, 64'd0);
    exp_tag = 6'd22;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_word = 1'b0; in_a = 64'd5; in_b = 64'd0; in_tag = 6'd22;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("done_before_flush", {63'd0, out_valid}, 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_done_in_ready", {63'd0, in_ready}, 64'd1);

    run_op(2'd1, 1'b0, 64'd77, 64'd7, 6'd23, 0, 1'b1, 64'd11);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      sel = $urandom_range(0, 4);
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = 64'($urandom_range(1, 20));
      else if (sel == 2) rb = -64'($urandom_range(1, 9));
      else               rb = {$urandom, $urandom};
      run_op(rop, rw, ra, rb, 6'(i + 30), 0, 1'b0, '0);
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_word = 1'b0; in_a = 64'd999; in_b = 64'd4; in_tag = 6'h2A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_result", out_result, 64'd0);
    check("midrst_out_tag", {58'd0, out_tag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd0, 1'b1, 64'hFFFF_FFF0, 64'd3, 6'd63, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
